// File: rtl/signed_shift_divide_pipe.sv
// Signed/unsigned shift and power-of-two divide: ASR, LSR, DIV (round toward zero), ASL with overflow.
// Latency 2 cycles (stage 1: shift + sticky/overflow, stage 2: DIV rounding increment).
// Backpressure: a stage advances when empty or when the next stage advances; up_ready follows down_ready combinationally.
module signed_shift_divide_pipe #(
    parameter int N  = 8,
    parameter int SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic [1:0]    up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          down_flag
);
    localparam int LOGN = $clog2(N);

    typedef enum logic [1:0] {
        MODE_ASR = 2'b00,
        MODE_LSR = 2'b01,
        MODE_DIV = 2'b10,
        MODE_ASL = 2'b11
    } mode_e;

    logic r_fill;
    assign r_fill = (up_mode == MODE_LSR) ? 1'b0 : up_data[N-1];

    // Log-depth barrel shifters; each stage also collects the bits it drops
    // (sticky for right shifts, sign disagreement for left shifts).
    for (genvar b = 0; b < LOGN; b++) begin : g_st
        localparam int K = 2 ** b;
        logic [N-1:0] r_in, r_out, l_in, l_out;
        logic         stk_in, stk_out, ovf_in, ovf_out;
        logic [K:0]   l_top;

        if (b == 0) begin : g_first
            assign r_in   = up_data;
            assign l_in   = up_data;
            assign stk_in = 1'b0;
            assign ovf_in = 1'b0;
        end else begin : g_next
            assign r_in   = g_st[b-1].r_out;
            assign l_in   = g_st[b-1].l_out;
            assign stk_in = g_st[b-1].stk_out;
            assign ovf_in = g_st[b-1].ovf_out;
        end

        assign l_top   = l_in[N-1:N-1-K];
        assign r_out   = up_shamt[b] ? {{K{r_fill}}, r_in[N-1:K]} : r_in;
        assign stk_out = stk_in | (up_shamt[b] & (|r_in[K-1:0]));
        assign l_out   = up_shamt[b] ? {l_in[N-1-K:0], {K{1'b0}}} : l_in;
        assign ovf_out = ovf_in | (up_shamt[b] & ~((&l_top) | ~(|l_top)));
    end

    logic          big;
    logic [N-1:0]  shift_val;
    logic          shift_flag;

    // Shifts of N or more bypass the shifter: every operand bit is dropped.
    always_comb begin
        big = (up_shamt >= SW'(N));
        if (up_mode == MODE_ASL) begin
            shift_val  = big ? '0 : g_st[LOGN-1].l_out;
            shift_flag = big ? (|up_data) : g_st[LOGN-1].ovf_out;
        end else begin
            shift_val  = big ? {N{r_fill}} : g_st[LOGN-1].r_out;
            shift_flag = big ? (|up_data) : g_st[LOGN-1].stk_out;
        end
    end

    logic         s1_vld_q, s1_vld_d;
    logic [N-1:0] s1_val_q, s1_val_d;
    logic         s1_flag_q, s1_flag_d;
    logic         s1_neg_q, s1_neg_d;
    mode_e        s1_mode_q, s1_mode_d;
    logic         s2_vld_q, s2_vld_d;
    logic [N-1:0] s2_dat_q, s2_dat_d;
    logic         s2_flag_q, s2_flag_d;
    logic         s1_adv, s2_adv;

    always_comb begin
        s2_adv    = !s2_vld_q || down_ready;
        s1_adv    = !s1_vld_q || s2_adv;
        s1_vld_d  = s1_vld_q;
        s1_val_d  = s1_val_q;
        s1_flag_d = s1_flag_q;
        s1_neg_d  = s1_neg_q;
        s1_mode_d = s1_mode_q;
        s2_vld_d  = s2_vld_q;
        s2_dat_d  = s2_dat_q;
        s2_flag_d = s2_flag_q;
        if (s1_adv) begin
            s1_vld_d = up_valid;
            if (up_valid) begin
                s1_val_d  = shift_val;
                s1_flag_d = shift_flag;
                s1_neg_d  = up_data[N-1];
                s1_mode_d = mode_e'(up_mode);
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                // Floor result of a negative inexact quotient is one below the truncated one.
                if (s1_mode_q == MODE_DIV && s1_neg_q && s1_flag_q)
                    s2_dat_d = s1_val_q + {{(N-1){1'b0}}, 1'b1};
                else
                    s2_dat_d = s1_val_q;
                s2_flag_d = s1_flag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_val_q  <= '0;
            s1_flag_q <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_mode_q <= MODE_ASR;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_flag_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_val_q  <= s1_val_d;
            s1_flag_q <= s1_flag_d;
            s1_neg_q  <= s1_neg_d;
            s1_mode_q <= s1_mode_d;
            s2_vld_q  <= s2_vld_d;
            s2_dat_q  <= s2_dat_d;
            s2_flag_q <= s2_flag_d;
        end
    end

    assign up_ready   = s1_adv;
    assign down_valid = s2_vld_q;
    assign down_data  = s2_dat_q;
    assign down_flag  = s2_flag_q;
endmodule
